fifo_lvl: RTL and testbench

Parametrised synchronous FIFO with fill-level reporting, programmable almost-full/almost-empty thresholds, synchronous flush and fully defined simultaneous read/write behaviour at every boundary. It replaces the plain UART RX/TX buffers: the UART RX path uses `almost_full` for flow control, and the TX path uses `almost_empty` to request refills. The read port is show-ahead: the head word is always presented on `r_data`.

---
 rtl/fifo_lvl.sv | 128 ++++++++++++
 tb/tb_fifo_lvl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_lvl.sv
// fifo_lvl: synchronous show-ahead FIFO with fill level, almost-full/empty
// thresholds, synchronous flush and defined wr+rd behaviour at every boundary.
// Optional feature macro: FIFO_ERR_FLAGS_EN (sticky overflow/underflow + err_clr).
module fifo_lvl #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = (1 << W) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow,
  input  logic         err_clr
);

  localparam int         DEPTH    = 1 << W;
  localparam logic [W:0] LP_DEPTH = (W+1)'(DEPTH);
  localparam logic [W:0] LP_AF    = (W+1)'(AF_LEVEL);
  localparam logic [W:0] LP_AE    = (W+1)'(AE_LEVEL);

  logic [B-1:0] r_mem [0:DEPTH-1];
  logic [W-1:0] r_wr_ptr;
  logic [W-1:0] r_rd_ptr;
  logic [W:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags are decoded from the level register only.
  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);

  // A write while full is still accepted when a read frees the head slot
  // in the same cycle; flush overrides both requests.
  assign w_wr_acc = wr & ~flush & (~w_full | rd);
  assign w_rd_acc = rd & ~flush & ~w_empty;

  // Storage array: no reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= w_data;
    end
  end

  // Pointers and level; flush zeroes them without touching memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign r_data       = r_mem[r_rd_ptr];
  assign empty        = w_empty;
  assign full         = w_full;
  assign level        = r_level;
  assign almost_empty = (r_level <= LP_AE);
  assign almost_full  = (r_level >= LP_AF);

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Offending requests: a write dropped because full, a read while empty.
  assign w_ovf_evt = wr & ~flush & w_full & ~rd;
  assign w_udf_evt = rd & ~flush & w_empty;

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: scoreboard bench for fifo_lvl. A queue-based reference model
// predicts the state after each edge; a monitor compares after every edge.
module tb_fifo_lvl;

  localparam int B     = 8;
  localparam int W     = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 1;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wr = 1'b0;
  logic [B-1:0] w_data = '0;
  logic         rd = 1'b0;
  logic         err_clr = 1'b0;
  logic [B-1:0] r_data;
  logic         empty, full, almost_empty, almost_full;
  logic [W:0]   level;
  logic         overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int       lvl;
    bit [7:0] head;
    bit       ov;
    bit       un;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] mq[$];
  bit       m_ov = 1'b0;
  bit       m_un = 1'b0;

  fifo_lvl #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .w_data(w_data),
    .rd(rd), .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Compare every output against the model's prediction for this edge.
  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, " level"}, int'(level), e.lvl);
    chk({tag, " empty"}, int'(empty), int'(e.lvl == 0));
    chk({tag, " full"}, int'(full), int'(e.lvl == DEPTH));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(e.lvl <= AE));
    chk({tag, " almost_full"}, int'(almost_full), int'(e.lvl >= AF));
    chk({tag, " overflow"}, int'(overflow), int'(e.ov));
    chk({tag, " underflow"}, int'(underflow), int'(e.un));
    if (e.lvl != 0) chk({tag, " r_data"}, int'(r_data), int'(e.head));
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.lvl  = mq.size();
    e.head = (mq.size() != 0) ? mq[0] : 8'h00;
    e.ov   = m_ov;
    e.un   = m_un;
    return e;
  endfunction

  // One clock of stimulus: drive, advance the model, queue the expectation.
  task automatic step(input bit i_wr, input bit i_rd, input bit i_fl,
                      input bit i_clr, input bit [7:0] i_d);
    bit was_full, was_empty, ov_evt, un_evt;
    @(negedge clk);
    wr = i_wr; rd = i_rd; flush = i_fl; err_clr = i_clr; w_data = i_d;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    ov_evt = 1'b0;
    un_evt = 1'b0;
    if (i_fl) begin
      mq.delete();
    end else begin
      ov_evt = i_wr && was_full && !i_rd;
      un_evt = i_rd && was_empty;
      if (i_rd && !was_empty) void'(mq.pop_front());
      if (i_wr && (!was_full || i_rd)) mq.push_back(i_d);
    end
    if (i_clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_ov = ERR_EN && (m_ov || ov_evt);
      m_un = ERR_EN && (m_un || un_evt);
    end
    exp_q.push_back(snap());
  endtask

  // Monitor: after each rising edge, pop one prediction and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp_all("sb", e);
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, " level"}, int'(level), 0);
    chk({tag, " empty"}, int'(empty), 1);
    chk({tag, " full"}, int'(full), 0);
    chk({tag, " almost_empty"}, int'(almost_empty), 1);
    chk({tag, " almost_full"}, int'(almost_full), 0);
    chk({tag, " overflow"}, int'(overflow), 0);
    chk({tag, " underflow"}, int'(underflow), 0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    // Fill with 0x00..0x0F, then a dropped 17th write, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00);
    $display("fill/overflow/drain done: level=%0d", level);

    // Read while empty, then clear the sticky flags
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    $display("underflow/err_clr done: underflow=%0b", underflow);

    // Full with simultaneous wr+rd across pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 8'(8'h80 + i));
    $display("full wr+rd streaming done: level=%0d full=%0b", level, full);

    // Empty with wr+rd: write wins, read flagged as underflow
    step(0, 0, 1, 1, 8'h00);
    step(1, 1, 0, 0, 8'h5A);
    $display("empty wr+rd done: r_data=%0h", r_data);

    // Flush at level 5 with a same-cycle write, then write 0x33
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    step(1, 1, 1, 1, 8'hEE);
    step(1, 0, 0, 0, 8'h33);
    $display("flush done: r_data=%0h level=%0d", r_data, level);

    // Randomised traffic with varying bias
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = (i < 1000) ? 75 : (i < 2000) ? 30 : 55;
      step($urandom_range(99) < pw, $urandom_range(99) < 50,
           $urandom_range(99) < 2, $urandom_range(99) < 4, 8'($urandom));
    end
    $display("random phase done: level=%0d", level);

    // Asynchronous reset between edges at level 7
    step(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'hC0 + i));
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'hC7);
    step(1, 0, 0, 0, 8'hC8);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
    chk("pre_reset level", int'(level), 7);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    $display("async reset done: level=%0d empty=%0b", level, empty);
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h00);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
